// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: state numbers,
// opcodes, datapath select codes and the internal control word.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD       = 2'b00;
    localparam logic [1:0] ALUOP_SUB       = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT     = 2'b10;
    localparam logic [1:0] ALUOP_IMM_LOGIC = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_word_t;

    // State entered after DECODE; unsupported opcodes fall back to FETCH.
    function automatic logic [3:0] decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:            return S_MEMADR;
            OP_RTYPE:                return S_EXEC;
            OP_BEQ:                  return S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: return S_IEXEC;
            OP_J:                    return S_JUMP;
            default:                 return S_FETCH;
        endcase
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decode for the multicycle MIPS control.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    logic imm_logic;

    assign imm_logic = (opcode == OP_ANDI) || (opcode == OP_ORI);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.pc_src    = PCSRC_ALU;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target computed while the opcode is decoded
                cw.alu_src_b  = SRCB_IMM_SH2;
                cw.alu_op     = ALUOP_ADD;
                cw.illegal_op = !op_is_legal(opcode);
            end
            S_MEMADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.iord = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                cw.iord      = 1'b1;
                cw.mem_write = 1'b1;
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALUOP_SUB;
                cw.branch    = 1'b1;
                cw.pc_src    = PCSRC_ALUOUT;
            end
            S_IEXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.ext_zero  = imm_logic;
                cw.alu_op    = imm_logic ? ALUOP_IMM_LOGIC : ALUOP_ADD;
            end
            S_IWB: begin
                cw.reg_write = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = PCSRC_JUMP;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic and reset gating of the write enables.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Datapath width is documentation only; the control path is width-agnostic.
    if (ADDR_W < 1) begin : g_addr_w_unused
    end

    ctrl_word_t cw;
    logic [3:0] state_nxt;

    mips_ctrl_outdec u_outdec (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .cw        (cw)
    );

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_nxt = decode_target(opcode);
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_IEXEC:  state_nxt = S_IWB;
            S_IWB:    state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Write enables are killed the instant reset rises so no access completes.
    assign pc_en      = !reset && (cw.pc_write || (cw.branch && zero));
    assign mem_write  = !reset && cw.mem_write;
    assign ir_write   = !reset && cw.ir_write;
    assign reg_write  = !reset && cw.reg_write;

    assign iord       = cw.iord;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign ext_zero   = cw.ext_zero;
    assign alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;
    assign illegal_op = cw.illegal_op;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle expected control
// vectors are queued with the stimulus and popped against the DUT each cycle.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst;
    logic       mem_to_reg, alu_src_a, ext_zero, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        rdy;
        logic [19:0] exp;
    } step_t;

    step_t sb[$];
    logic [19:0] obs;

    multicycle_main_control #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, pc_en, iord, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, pc_src,
                  illegal_op};

    function automatic logic [19:0] cw(input logic [3:0] st, input logic pe,
                                       input logic io, input logic mw,
                                       input logic irw, input logic rw,
                                       input logic rd, input logic m2r,
                                       input logic sa, input logic [1:0] sbs,
                                       input logic ez, input logic [1:0] ao,
                                       input logic [1:0] ps, input logic ill);
        return {st, pe, io, mw, irw, rw, rd, m2r, sa, sbs, ez, ao, ps, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic rdy, input logic [19:0] e);
        step_t s;
        s.tag = tag;
        s.rdy = rdy;
        s.exp = e;
        sb.push_back(s);
    endtask

    task automatic push_fetch(input string tag);
        push({tag, "_fetch"}, 1'b1, cw(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0));
    endtask

    task automatic push_decode(input string tag, input logic ill);
        push({tag, "_decode"}, 1'b1, cw(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, ill));
    endtask

    // Each queued step: drive mem_ready, settle, compare, advance one cycle.
    task automatic run_queue();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            mem_ready = s.rdy;
            #1;
            check(s.tag, {12'd0, obs}, {12'd0, s.exp});
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b101011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_ir_write", {31'd0, ir_write}, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        #1 reset = 1'b0;
        #1;
        check("fetch_ir_write", {31'd0, ir_write}, 32'd1);
        #25;
        check("sw_pre_state", {28'd0, state}, 32'd5);
        check("sw_pre_mem_write", {31'd0, mem_write}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midwr_mem_write", {31'd0, mem_write}, 32'd0);
        check("midwr_state", {28'd0, state}, 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // post-reset FETCH stall, then lw with mem_ready tied high
        opcode = 6'b100011;
        push("post_rst_stall", 1'b0, cw(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0));
        push_fetch("lw");
        push_decode("lw", 1'b0);
        push("lw_memadr", 1'b1, cw(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0));
        push("lw_memrd", 1'b1, cw(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        push("lw_memwb", 1'b1, cw(4'd4, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        run_queue();

        // sw stalled three cycles in MEMWR
        opcode = 6'b101011;
        push_fetch("sw");
        push_decode("sw", 1'b0);
        push("sw_memadr", 1'b1, cw(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0));
        for (int i = 0; i < 3; i++)
            push("sw_memwr_wait", 1'b0, cw(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        push("sw_memwr_done", 1'b1, cw(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        run_queue();

        // beq taken then not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        push_fetch("beq_t");
        push_decode("beq_t", 1'b0);
        push("beq_t_branch", 1'b1, cw(4'd8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 0));
        run_queue();
        zero = 1'b0;
        push_fetch("beq_nt");
        push_decode("beq_nt", 1'b0);
        push("beq_nt_branch", 1'b1, cw(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 0));
        run_queue();

        // ori then addi
        opcode = 6'b001101;
        push_fetch("ori");
        push_decode("ori", 1'b0);
        push("ori_iexec", 1'b1, cw(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b11, 2'b00, 0));
        push("ori_iwb", 1'b1, cw(4'd10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        run_queue();
        opcode = 6'b001000;
        push_fetch("addi");
        push_decode("addi", 1'b0);
        push("addi_iexec", 1'b1, cw(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0));
        push("addi_iwb", 1'b1, cw(4'd10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        run_queue();

        // R-type
        opcode = 6'b000000;
        push_fetch("rtype");
        push_decode("rtype", 1'b0);
        push("rtype_exec", 1'b1, cw(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b10, 2'b00, 0));
        push("rtype_aluwb", 1'b1, cw(4'd7, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0));
        run_queue();

        // illegal opcode: single-cycle pulse then back to FETCH
        opcode = 6'b111111;
        push_fetch("ill");
        push_decode("ill", 1'b1);
        push("ill_refetch", 1'b0, cw(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0));
        run_queue();

        // jump
        opcode = 6'b000010;
        push_fetch("j");
        push_decode("j", 1'b0);
        push("j_jump", 1'b1, cw(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 0));
        push("j_back_fetch", 1'b0, cw(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0));
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
